// File: rtl/dct_pkg.sv
// Shared types and constants for the DCT row scheduler.
// Holds the FSM state type, drain margin and issue-order helper.
package dct_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SUM   = 2'd1,
        DIFF  = 2'd2,
        DRAIN = 2'd3
    } dct_sched_state_e;

    // Extra cycles allowed in DRAIN beyond one row of z beats
    localparam int DRAIN_MARGIN = 4;

    // Bank entry driven on pass cycle idx: pairs x[k] with x[n-1-k]
    function automatic int issue_pos(input int idx, input int n);
        return (idx % 2 == 0) ? idx / 2 : n - 1 - idx / 2;
    endfunction

endpackage

// File: rtl/dct_row_pingpong.sv
// Two-bank row buffer for the DCT row scheduler.
// Write side fills banks in turn; read side releases them in turn.
module dct_row_pingpong
    import dct_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 8,
    parameter int IDX_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  rd_release,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_full,
    output logic                  nx_full,
    output logic                  any_full
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    logic [DATA_WIDTH-1:0] mem [2][N];
    logic [IDX_W-1:0]      wr_ptr;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [1:0]            full;
    logic [1:0]            full_nxt;
    logic                  wr_en;
    logic                  wr_last;

    assign in_ready = !full[wr_bank];
    assign wr_en    = in_valid && in_ready;
    assign wr_last  = wr_en && (wr_ptr == IDX_LAST);
    assign rd_data  = mem[rd_bank][rd_idx];
    assign rd_full  = full[rd_bank];
    assign nx_full  = full[~rd_bank];
    assign any_full = |full;

    // Fill of the write bank and release of the read bank are independent
    always_comb begin
        full_nxt = full;
        if (rd_release) full_nxt[rd_bank] = 1'b0;
        if (wr_last)    full_nxt[wr_bank] = 1'b1;
    end

    // Pointers and full flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            full    <= '0;
        end else begin
            full <= full_nxt;
            if (wr_en) wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;
            if (wr_last) wr_bank <= ~wr_bank;
            if (rd_release) rd_bank <= ~rd_bank;
        end
    end

    // Sample storage; contents are qualified by the full flags
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_bank][wr_ptr] <= in_data;
    end

endmodule

// File: rtl/dct_row_sched.sv
// DCT row scheduler: buffers pixel rows and issues sum/diff passes.
// Optional perf counters are built when DCT_ROW_SCHED_PERF_EN is defined.
module dct_row_sched
    import dct_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 8,
    parameter int ROWS       = 8,
    parameter int Z_LATENCY  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] arr_x,
    output logic                  arr_sum_diff_sel,
    output logic                  arr_load,
    input  logic                  z_valid,
    output logic                  dct_sel,
    output logic                  row_done,
    output logic                  block_done,
    output logic                  busy
`ifdef DCT_ROW_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_rows
`endif
);

    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;
    localparam int ROW_W   = $clog2(ROWS + 1);
    localparam int Z_W     = $clog2(2 * N);
    localparam int TOTAL_Z = ROWS * 2 * N;
    localparam int BLK_W   = $clog2(TOTAL_Z + 1);
    localparam int TMO     = Z_LATENCY + 2 * N + DRAIN_MARGIN;
    localparam int TMO_W   = $clog2(TMO + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [Z_W-1:0]   Z_LAST   = Z_W'(2 * N - 1);
    localparam logic [Z_W-1:0]   Z_HALF   = Z_W'(N);
    localparam logic [BLK_W-1:0] BLK_MAX  = BLK_W'(TOTAL_Z);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);

    dct_sched_state_e      state;
    dct_sched_state_e      state_nxt;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_nxt;
    logic [IDX_W-1:0]      rd_idx;
    logic [ROW_W-1:0]      row_cnt;
    logic [Z_W-1:0]        z_cnt;
    logic [Z_W-1:0]        z_cnt_nxt;
    logic [BLK_W-1:0]      blk_z;
    logic [TMO_W-1:0]      drain_tmr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] iss_x;
    logic                  iss_sel;
    logic                  iss_load;
    logic                  issuing;
    logic                  last_idx;
    logic                  end_diff;
    logic                  drain_exit;
    logic                  rd_full;
    logic                  nx_full;
    logic                  any_full;

    dct_row_pingpong #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .IDX_W      (IDX_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rd_release (end_diff),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .rd_full    (rd_full),
        .nx_full    (nx_full),
        .any_full   (any_full)
    );

    assign issuing  = (state == SUM) || (state == DIFF);
    assign last_idx = (idx == IDX_LAST);
    assign end_diff = (state == DIFF) && last_idx;
    assign rd_idx   = IDX_W'(issue_pos(int'(idx), N));
    assign busy     = any_full || (state != IDLE);

    assign drain_exit = (state == DRAIN) &&
                        ((blk_z == BLK_MAX) ||
                         ((drain_tmr == TMO_LAST) && !z_valid));

    // State, pass index, row count and registered array outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            idx              <= '0;
            row_cnt          <= '0;
            arr_x            <= '0;
            arr_sum_diff_sel <= 1'b0;
            arr_load         <= 1'b0;
        end else begin
            state            <= state_nxt;
            idx              <= idx_nxt;
            arr_x            <= iss_x;
            arr_sum_diff_sel <= iss_sel;
            arr_load         <= iss_load;
            if (end_diff) begin
                row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
            end
        end
    end

    // Next state: whole rows only, back-to-back when the next bank is ready
    always_comb begin
        state_nxt = state;
        idx_nxt   = '0;
        unique case (state)
            IDLE: begin
                if (rd_full) state_nxt = SUM;
            end
            SUM: begin
                idx_nxt = last_idx ? '0 : idx + 1'b1;
                if (last_idx) state_nxt = DIFF;
            end
            DIFF: begin
                idx_nxt = last_idx ? '0 : idx + 1'b1;
                if (last_idx) begin
                    if (row_cnt == ROW_LAST) state_nxt = DRAIN;
                    else if (nx_full)        state_nxt = SUM;
                    else                     state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (drain_exit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Issue values presented to the output registers
    always_comb begin
        iss_x    = '0;
        iss_sel  = 1'b0;
        iss_load = 1'b0;
        if (issuing) begin
            iss_x    = rd_data;
            iss_sel  = (state == DIFF);
            iss_load = (idx == '0);
        end
    end

    assign z_cnt_nxt = !z_valid ? z_cnt :
                       (z_cnt == Z_LAST) ? '0 : z_cnt + 1'b1;

    // z beat position within a row drives the sum/diff stage select
    always_ff @(posedge clk) begin
        if (rst) begin
            z_cnt    <= '0;
            dct_sel  <= 1'b1;
            row_done <= 1'b0;
        end else begin
            z_cnt    <= z_cnt_nxt;
            dct_sel  <= (z_cnt_nxt < Z_HALF);
            row_done <= z_valid && (z_cnt == Z_LAST);
        end
    end

    // Block z accounting and drain watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_z      <= '0;
            drain_tmr  <= '0;
            block_done <= 1'b0;
        end else begin
            block_done <= drain_exit;
            if (drain_exit) begin
                blk_z <= '0;
            end else if (z_valid && (blk_z != BLK_MAX)) begin
                blk_z <= blk_z + 1'b1;
            end
            if ((state != DRAIN) || z_valid) begin
                drain_tmr <= '0;
            end else if (drain_tmr != TMO_LAST) begin
                drain_tmr <= drain_tmr + 1'b1;
            end
        end
    end

`ifdef DCT_ROW_SCHED_PERF_EN
    // Saturating stall and completed-row counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_rows         <= '0;
        end else begin
            if ((state == IDLE) && busy && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            end
            if (row_done && (perf_rows != '1)) begin
                perf_rows <= perf_rows + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dct_row_sched.sv
// Directed/random bench for dct_row_sched.
// Issue trace is compared to a row model built from accepted samples.
module tb_dct_row_sched;

    localparam int N   = 8;
    localparam int RWS = 8;
    localparam int ZL  = 10;
    localparam int TMO = ZL + 2 * N + 4;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  x;
        logic        sel;
        logic        load;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] arr_x;
    logic       arr_sum_diff_sel;
    logic       arr_load;
    logic       z_valid;
    logic       dct_sel;
    logic       row_done;
    logic       block_done;
    logic       busy;
`ifdef DCT_ROW_SCHED_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_rows;
`endif

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   mon_left = 0;
    int   rd_cnt = 0;
    int   rd_cyc = 0;
    int   bd_cnt = 0;
    int   bd_cyc = 0;
    int   stall_cnt = 0;
    rec_t recs[$];
    int   smp[$];
    int   acc[$];

    dct_row_sched dut (
        .clk              (clk),
        .rst              (rst),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .arr_x            (arr_x),
        .arr_sum_diff_sel (arr_sum_diff_sel),
        .arr_load         (arr_load),
        .z_valid          (z_valid),
        .dct_sel          (dct_sel),
        .row_done         (row_done),
        .block_done       (block_done),
        .busy             (busy)
`ifdef DCT_ROW_SCHED_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_rows        (perf_rows)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every beat of each pass, framed by arr_load
    always @(negedge clk) begin
        if (rst) begin
            mon_left <= 0;
        end else if (arr_load) begin
            recs.push_back({cyc, arr_x, arr_sum_diff_sel, arr_load});
            mon_left <= N - 1;
        end else if (mon_left > 0) begin
            recs.push_back({cyc, arr_x, arr_sum_diff_sel, arr_load});
            mon_left <= mon_left - 1;
        end
        if (row_done) begin
            rd_cnt <= rd_cnt + 1;
            rd_cyc <= cyc;
        end
        if (block_done) begin
            bd_cnt <= bd_cnt + 1;
            bd_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        in_valid = 1'b0;
        z_valid = 1'b0;
        tick();
        chk({tag, "_rst_x"}, arr_x, 0);
        chk({tag, "_rst_sel"}, arr_sum_diff_sel, 0);
        chk({tag, "_rst_load"}, arr_load, 0);
        chk({tag, "_rst_rdone"}, row_done, 0);
        chk({tag, "_rst_bdone"}, block_done, 0);
        chk({tag, "_rst_busy"}, busy, 0);
        chk({tag, "_rst_ready"}, in_ready, 1);
        chk({tag, "_rst_dsel"}, dct_sel, 1);
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] v, input int gap);
        int t;
        t = 0;
        repeat (gap) begin
            in_valid = 1'b0;
            tick();
        end
        in_data = v;
        in_valid = 1'b1;
        while (!in_ready && t < 300) begin
            tick();
            t++;
        end
        stall_cnt += t;
        if (t > 0) chk("send_ready", in_ready, 1);
        tick();
        acc.push_back(cyc);
        smp.push_back(int'(v));
        in_valid = 1'b0;
    endtask

    task automatic zfeed(input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, maxgap)) begin
                z_valid = 1'b0;
                tick();
            end
            z_valid = 1'b1;
            tick();
        end
        z_valid = 1'b0;
    endtask

    task automatic wait_recs(input int target, input int budget);
        int t;
        t = 0;
        while (recs.size() < target && t < budget) begin
            tick();
            t++;
        end
        chk("wait_recs", recs.size() >= target, 1);
    endtask

    task automatic wait_bd(input int target, input int budget);
        int t;
        t = 0;
        while (bd_cnt < target && t < budget) begin
            tick();
            t++;
        end
        chk("wait_block_done", bd_cnt >= target, 1);
    endtask

    // Expected: per row a sum pass then a diff pass, each pairing
    // sample k with sample N-1-k, load only on the first beat.
    task automatic chk_trace(input string tag, input int rb, input int sb,
                             input int nrows);
        chk({tag, "_len"}, recs.size() - rb, nrows * 2 * N);
        if (recs.size() - rb >= nrows * 2 * N &&
            smp.size() - sb >= nrows * N) begin
            for (int r = 0; r < nrows; r++) begin
                for (int p = 0; p < 2; p++) begin
                    for (int c = 0; c < N; c++) begin
                        int   k;
                        int   pos;
                        rec_t e;
                        k   = c / 2;
                        pos = (c % 2 == 0) ? k : N - 1 - k;
                        e   = recs[rb + r * 2 * N + p * N + c];
                        chk({tag, "_x"}, e.x, smp[sb + r * N + pos]);
                        chk({tag, "_sel"}, e.sel, p);
                        chk({tag, "_load"}, e.load, c == 0);
                    end
                end
            end
        end
    endtask

    task automatic run_block(input string tag);
        int rb;
        int sb;
        int r0;
        int b0;
        rb = recs.size();
        sb = smp.size();
        r0 = rd_cnt;
        b0 = bd_cnt;
        for (int i = 0; i < RWS * N; i++) begin
            send(8'($urandom), $urandom_range(0, 1));
        end
        zfeed(RWS * 2 * N, 2);
        wait_bd(b0 + 1, 200);
        repeat (4) tick();
        chk({tag, "_rows"}, rd_cnt - r0, RWS);
        chk({tag, "_blocks"}, bd_cnt - b0, 1);
        chk({tag, "_order"}, bd_cyc > rd_cyc, 1);
        chk({tag, "_busy"}, busy, 0);
        chk_trace(tag, rb, sb, RWS);
    endtask

    initial begin
        int rb;
        int sb;
        int ab;
        int r0;
        int b0;
        int st0;
        int zc;
        rst = 1'b1;
        in_data = '0;
        in_valid = 1'b0;
        z_valid = 1'b0;

        // Single row 1..8 at full rate
        do_reset("t1");
        rb = recs.size();
        sb = smp.size();
        ab = acc.size();
        st0 = stall_cnt;
        for (int i = 1; i <= N; i++) send(8'(i), 0);
        chk("t1_ready_held", stall_cnt - st0, 0);
        wait_recs(rb + 2 * N, 60);
        repeat (3) tick();
        chk_trace("t1", rb, sb, 1);
        if (recs.size() > rb) begin
            chk("t1_latency", recs[rb].cyc, acc[ab + N - 1] + 2);
        end
        chk("t1_busy", busy, 0);

        // Two rows back to back: no bubble between rows
        do_reset("t2");
        rb = recs.size();
        sb = smp.size();
        for (int i = 0; i < 2 * N; i++) send(8'($urandom), 0);
        wait_recs(rb + 4 * N, 100);
        repeat (3) tick();
        chk_trace("t2", rb, sb, 2);
        if (recs.size() > rb + 2 * N) begin
            chk("t2_bubble", recs[rb + 2 * N].cyc,
                recs[rb + 2 * N - 1].cyc + 1);
        end

        // Three rows: buffer full until first row is released
        do_reset("t3");
        rb = recs.size();
        sb = smp.size();
        ab = acc.size();
        for (int i = 0; i < 2 * N; i++) send(8'($urandom), 0);
        chk("t3_full", in_ready, 0);
        for (int i = 0; i < N; i++) send(8'($urandom), 0);
        if (recs.size() >= rb + 2 * N) begin
            chk("t3_acc17", acc[ab + 2 * N], recs[rb + 2 * N - 1].cyc + 1);
        end
        wait_recs(rb + 6 * N, 150);
        repeat (3) tick();
        chk_trace("t3", rb, sb, 3);

        // z tracking over one row
        do_reset("t4");
        r0 = rd_cnt;
        for (int k = 0; k < 2 * N; k++) begin
            z_valid = 1'b1;
            chk("t4_dct_sel", dct_sel, k < N);
            tick();
        end
        z_valid = 1'b0;
        zc = cyc;
        repeat (3) tick();
        chk("t4_row_done_cnt", rd_cnt - r0, 1);
        chk("t4_row_done_t", rd_cyc, zc);
        chk("t4_sel_wrap", dct_sel, 1);

        // Full block with z beats
        do_reset("t5");
        run_block("t5");

        // Reset in the middle of row 3's diff pass
        do_reset("t6");
        rb = recs.size();
        r0 = rd_cnt;
        b0 = bd_cnt;
        zfeed(10, 0);
        for (int i = 0; i < 3 * N; i++) send(8'($urandom), 0);
        wait_recs(rb + 5 * N + 2, 200);
        do_reset("t6mid");
        chk("t6_rows", rd_cnt - r0, 0);
        chk("t6_blocks", bd_cnt - b0, 0);
        zfeed(6, 0);
        repeat (3) tick();
        chk("t6_zcnt_cleared", rd_cnt - r0, 0);
        do_reset("t6b");
        run_block("t6blk");

        // Drain watchdog with no z beats at all
        do_reset("t7");
        rb = recs.size();
        sb = smp.size();
        r0 = rd_cnt;
        b0 = bd_cnt;
        for (int i = 0; i < RWS * N; i++) send(8'($urandom), 0);
        wait_recs(rb + RWS * 2 * N, 300);
        wait_bd(b0 + 1, 80);
        if (recs.size() >= rb + RWS * 2 * N) begin
            chk("t7_timeout", bd_cyc, recs[rb + RWS * 2 * N - 1].cyc + TMO);
        end
        chk("t7_rows", rd_cnt - r0, 0);
        chk("t7_busy", busy, 0);
        chk_trace("t7", rb, sb, RWS);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
